// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned IFID_W    = 64;  // {pc[31:0], instr[31:0]}

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by the asynchronous reset.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush/hold, and saturating bubble/stall counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W    = IFID_W,
  parameter logic [DATA_W-1:0]    FLUSH_VAL = {DATA_W{1'b0}},
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              acc, fire;

  // ready_o depends only on state, so no combinational path from ready_i.
  assign valid_o = (state_q != EMPTY);
  assign ready_o = (state_q != TWO);
  assign data_o  = main_q;
  assign acc     = valid_i & ready_o;
  assign fire    = valid_o & ready_i & ~hold_i;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = data_i;
          end
        end
        ONE: begin
          if (acc && fire) begin
            main_d  = data_i;
          end else if (acc) begin
            state_d = TWO;
            skid_d  = data_i;
          end else if (fire) begin
            state_d = EMPTY;  // main keeps the last delivered payload
          end
        end
        TWO: begin
          if (fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: payload storage is reset as well because data_o must show FLUSH_VAL
  // after reset, not merely be qualified by valid_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_VAL;
      skid_q  <= FLUSH_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~valid_o),
    .cnt_o (bubble_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (valid_o & ~fire),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline boundary register for the pipelined CPU, replacing fixed-width IF/ID-style stage registers. It carries an arbitrary payload (e.g. {pc, instr}) behind a valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered and no combinational ready path crosses the stage. It also supports synchronous flush and hold (legacy stall), and exposes saturating bubble and stall counters for performance debug.

Parameters:
DATA_W, 64, payload width in bits (IF/ID use: {pc[31:0], instr[31:0]}).
FLUSH_VAL, {DATA_W{1'b0}}, payload value loaded on reset and flush (all-zero = NOP instr, pc 0).
CNT_W, 16, width of each performance counter.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-low reset
valid_i  in  1  upstream payload valid
data_i  in  DATA_W  upstream payload
ready_o  out  1  stage can accept (registered)
valid_o  out  1  downstream payload valid
data_o  out  DATA_W  downstream payload
ready_i  in  1  downstream accepts
hold_i  in  1  freeze output (hazard stall); acts as ready_i=0
flush_i  in  1  discard all held and incoming payloads
bubble_cnt_o  out  CNT_W  cycles with valid_o=0
stall_cnt_o  out  CNT_W  cycles with valid_o=1 and not fired

Behaviour:
- Storage: main entry (drives data_o) and skid entry. State encoding: EMPTY, ONE (main valid), TWO (main+skid valid).
- Reset (rst_i=0, async): state EMPTY, main and skid <= FLUSH_VAL, valid_o=0, ready_o=1, both counters 0.
- Derived signals: valid_o = (state != EMPTY); ready_o = (state != TWO), taken from state, so it is a registered output; acc = valid_i & ready_o; fire = valid_o & ready_i & ~hold_i.
- Transitions when flush_i=0:
  - EMPTY: acc -> ONE, main<=data_i.
  - ONE: acc&fire -> ONE, main<=data_i. acc&~fire -> TWO, skid<=data_i. ~acc&fire -> EMPTY, main retains its value. Otherwise hold.
  - TWO: fire -> ONE, main<=skid. ~fire -> hold. acc cannot occur here because ready_o=0.
- Latency: 1 cycle from acc in EMPTY to valid_o. Throughput is 1 per cycle while ready_i=1 and hold_i=0.
- Ordering is strictly FIFO. No payload is ever duplicated or dropped, except by flush.
- flush_i=1 (synchronous, highest priority over hold_i, acc and fire):
  - Next state EMPTY; main and skid <= FLUSH_VAL.
  - A payload presented in the flush cycle is discarded even if ready_o=1.
  - A payload fired in the flush cycle counts as delivered.
- hold_i=1 with flush_i=0: output frozen, data_o stable. Upstream may still fill the skid entry (ONE -> TWO).
- data_o while valid_o=0: FLUSH_VAL after reset or flush, otherwise the last delivered value. Downstream must qualify data_o with valid_o.
- Counters:
  - Increment per cycle on the stated condition, evaluated from current-cycle state.
  - Saturate at 2^CNT_W-1; no wrap.
  - Cleared only by reset; flush does not clear them.
- Reset asserted mid-transfer: contents lost, outputs go to reset values immediately (asynchronous).

Decomposition:
- Package pipe_pkg: stage_state_t enum {EMPTY, ONE, TWO} (2 bits); constant NOP_INSTR = 32'h0000_0000; helper localparam for the IF/ID payload width (64).
- Sub-module sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice.

Test Plan:
- Reset release, no input -> valid_o=0, ready_o=1, data_o=FLUSH_VAL, bubble_cnt_o increments 1/cycle, stall_cnt_o=0.
- Stream A,B,C,D on consecutive cycles, ready_i=1 -> data_o = A,B,C,D one cycle after each input, valid_o continuous, ready_o stays 1.
- Send A,B with ready_i=0 -> after B, state TWO, ready_o=0, stall_cnt_o counts. Raise ready_i -> A then B delivered in order, no loss, ready_o=1 one cycle after A fires.
- State TWO (A,B), flush_i=1 with valid_i=1 data C -> next cycle valid_o=0, data_o=FLUSH_VAL, ready_o=1; C never appears at data_o.
- hold_i=1 with ready_i=1 while A valid -> A held stable, stall_cnt_o increments. Drop hold_i -> A fires once.
- Force CNT_W=4, idle 20 cycles -> bubble_cnt_o saturates at 15. Then assert rst_i=0 mid-transfer -> all outputs return to reset values immediately.
